// File: rtl/cnn_mac_pkg.sv
// Shared constants and helpers for the CNN multiply-accumulate pipe.
// Holds the default geometry, the result formatter and the signed-add overflow test.
// Functions are purely combinational and are used inside always_comb blocks.
package cnn_mac_pkg;

  // Default geometry: an 8-bit activation times a 14-bit weight, summed in 32 bits.
  localparam int A_W_DEF        = 8;
  localparam int B_W_DEF        = 14;
  localparam int ACC_W_DEF      = 32;
  localparam int OUT_W_DEF      = 22;
  localparam int MUL_STAGES_DEF = 2;
  localparam int SAT_EN_DEF     = 1;

  // The formatter works on a sign-extended 64-bit view of the accumulator.
  // Callers take the low OUT_W bits of the result.
  localparam int FMT_W = 64;

  // Clamp to the signed OUT_W range when sat_en is set. Otherwise pass the value
  // through, so the caller's truncation gives two's-complement wrap.
  function automatic logic signed [FMT_W-1:0] sat_fmt(
    input logic signed [FMT_W-1:0] acc,
    input int                      out_w,
    input logic                    sat_en
  );
    logic signed [FMT_W-1:0] hi;
    logic signed [FMT_W-1:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (sat_en && (acc > hi)) return hi;
    if (sat_en && (acc < lo)) return lo;
    return acc;
  endfunction

  // A two's-complement add overflows when both operands share a sign
  // and the sum has the other sign.
  function automatic logic add_ovf(
    input logic a_msb,
    input logic b_msb,
    input logic s_msb
  );
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/cnn_mac_if.sv
// Beat and result bundle between a producer and the MAC pipe.
// The producer drives ce, beats and operands. The pipe drives the result strobe and data.
// There is no ready signal: the consumer must take every out_valid that is qualified by ce.
interface cnn_mac_if
  import cnn_mac_pkg::*;
#(
  parameter int A_W   = A_W_DEF,
  parameter int B_W   = B_W_DEF,
  parameter int OUT_W = OUT_W_DEF
);
  logic                    ce;
  logic                    in_valid;
  logic                    in_first;
  logic                    in_last;
  logic signed [A_W-1:0]   din0;
  logic signed [B_W-1:0]   din1;
  logic                    out_valid;
  logic signed [OUT_W-1:0] dout;
  logic                    acc_ovf;

  modport master (
    output ce, in_valid, in_first, in_last, din0, din1,
    input  out_valid, dout, acc_ovf
  );

  modport slave (
    input  ce, in_valid, in_first, in_last, din0, din1,
    output out_valid, dout, acc_ovf
  );
endinterface

// File: rtl/cnn_mac_mul_pipe.sv
// Signed A_W x B_W multiplier with a pipeline of MUL_STAGES registers for product and sideband.
// Latency: MUL_STAGES ce-enabled edges from the input beat to the p_* outputs.
// There is no backpressure. When ce=0 every stage holds, and bubbles move through as bubbles.
module cnn_mac_mul_pipe
  import cnn_mac_pkg::*;
#(
  parameter int A_W        = A_W_DEF,
  parameter int B_W        = B_W_DEF,
  parameter int MUL_STAGES = MUL_STAGES_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ce,
  input  logic                      in_valid,
  input  logic                      in_first,
  input  logic                      in_last,
  input  logic signed [A_W-1:0]     din0,
  input  logic signed [B_W-1:0]     din1,
  output logic                      p_valid,
  output logic                      p_first,
  output logic                      p_last,
  output logic signed [A_W+B_W-1:0] p
);
  localparam int P_W = A_W + B_W;

  typedef struct packed {
    logic                  vld;
    logic                  first;
    logic                  last;
    logic signed [P_W-1:0] prod;
  } beat_t;

  // The multiply is written ahead of a plain register chain. Synthesis retimes
  // the chain into the DSP48 A/B, M and P registers, so any depth from 1 to 4
  // maps onto the slice.
  logic signed [P_W-1:0] prod;
  beat_t                 pipe_q [MUL_STAGES];
  beat_t                 pipe_d [MUL_STAGES];

  assign prod = P_W'(din0) * P_W'(din1);

  // Next state of the chain: stage 0 loads the new beat, later stages shift.
  always_comb begin
    pipe_d[0].vld   = in_valid;
    pipe_d[0].first = in_first;
    pipe_d[0].last  = in_last;
    pipe_d[0].prod  = prod;
    for (int i = 1; i < MUL_STAGES; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Chain registers. They stall as a whole when ce is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MUL_STAGES; i++) begin
        pipe_q[i] <= '0;
      end
    end else if (ce) begin
      for (int i = 0; i < MUL_STAGES; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign p_valid = pipe_q[MUL_STAGES-1].vld;
  assign p_first = pipe_q[MUL_STAGES-1].first;
  assign p_last  = pipe_q[MUL_STAGES-1].last;
  assign p       = pipe_q[MUL_STAGES-1].prod;

endmodule

// File: rtl/cnn_mac_pipe.sv
// Grouped signed multiply-accumulate with one saturated, overflow-flagged result per group.
// Latency: a last beat accepted at edge N produces out_valid after edge N+MUL_STAGES (ce edges only).
// There is no backpressure. ce=0 freezes all state, so out_valid is held and must be qualified by ce.
module cnn_mac_pipe
  import cnn_mac_pkg::*;
#(
  parameter int A_W        = A_W_DEF,
  parameter int B_W        = B_W_DEF,
  parameter int ACC_W      = ACC_W_DEF,
  parameter int OUT_W      = OUT_W_DEF,
  parameter int MUL_STAGES = MUL_STAGES_DEF,
  parameter int SAT_EN     = SAT_EN_DEF
) (
  input logic      clk,
  input logic      reset,
  cnn_mac_if.slave bus
);
  localparam int P_W = A_W + B_W;

  // Reject geometries that the datapath cannot represent.
  if (ACC_W < P_W || ACC_W > FMT_W) begin : g_bad_acc_w
    $error("cnn_mac_pipe: ACC_W must lie in [A_W+B_W, 64]");
  end
  if (OUT_W > ACC_W || OUT_W < 2) begin : g_bad_out_w
    $error("cnn_mac_pipe: OUT_W must lie in [2, ACC_W]");
  end
  if (MUL_STAGES < 1 || MUL_STAGES > 4) begin : g_bad_stages
    $error("cnn_mac_pipe: MUL_STAGES must lie in [1, 4]");
  end

  logic                  m_vld;
  logic                  m_first;
  logic                  m_last;
  logic signed [P_W-1:0] m_p;

  cnn_mac_mul_pipe #(
    .A_W        (A_W),
    .B_W        (B_W),
    .MUL_STAGES (MUL_STAGES)
  ) u_mul (
    .clk      (clk),
    .reset    (reset),
    .ce       (bus.ce),
    .in_valid (bus.in_valid),
    .in_first (bus.in_first),
    .in_last  (bus.in_last),
    .din0     (bus.din0),
    .din1     (bus.din1),
    .p_valid  (m_vld),
    .p_first  (m_first),
    .p_last   (m_last),
    .p        (m_p)
  );

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    ovf_q, ovf_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0] dout_q, dout_d;
  logic                    acc_ovf_q, acc_ovf_d;

  logic signed [ACC_W-1:0] p_ext;
  logic signed [ACC_W-1:0] acc_base;
  logic signed [ACC_W-1:0] acc_sum;
  logic                    ovf_nxt;

  // Accumulate datapath. A first beat restarts from zero, which can never
  // overflow, and clears the sticky flag inherited from an abandoned group.
  always_comb begin
    p_ext    = ACC_W'(m_p);
    acc_base = m_first ? '0 : acc_q;
    acc_sum  = acc_base + p_ext;
    ovf_nxt  = (m_first ? 1'b0 : ovf_q)
             | add_ovf(acc_base[ACC_W-1], p_ext[ACC_W-1], acc_sum[ACC_W-1]);
  end

  // Group control. A last beat publishes the formatted sum and clears the
  // accumulator, so a following beat without first still starts clean.
  always_comb begin
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    out_valid_d = 1'b0;
    dout_d      = dout_q;
    acc_ovf_d   = acc_ovf_q;
    if (m_vld) begin
      acc_d = acc_sum;
      ovf_d = ovf_nxt;
      if (m_last) begin
        out_valid_d = 1'b1;
        dout_d      = OUT_W'(sat_fmt(64'(acc_sum), OUT_W, SAT_EN != 0));
        acc_ovf_d   = ovf_nxt;
        acc_d       = '0;
        ovf_d       = 1'b0;
      end
    end
  end

  // Accumulator and output registers. They freeze together with the multiplier while ce is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      acc_ovf_q   <= 1'b0;
    end else if (bus.ce) begin
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      acc_ovf_q   <= acc_ovf_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.dout      = dout_q;
  assign bus.acc_ovf   = acc_ovf_q;

endmodule

// File: tb/tb_cnn_mac_pipe.sv
// Directed bench for cnn_mac_pipe. Three instances share one stimulus stream:
// the defaults, a truncating (SAT_EN=0) copy, and a 24-bit accumulator copy.
// Expected values below are hand-computed from the arithmetic of each vector.
module tb_cnn_mac_pipe;

  localparam int NONE = 32'h7fff_ffff;

  logic              clk = 1'b0;
  logic              rst;
  logic              ce;
  logic              in_valid;
  logic              in_first;
  logic              in_last;
  logic signed [7:0]  din0;
  logic signed [13:0] din1;

  int n_chk  = 0;
  int n_fail = 0;

  int q_sat[$];
  int q_trc[$];
  int q_a24[$];
  int o_sat[$];
  int o_a24[$];

  always #5 clk = ~clk;

  cnn_mac_if #(.A_W(8), .B_W(14), .OUT_W(22)) bus_sat ();
  cnn_mac_if #(.A_W(8), .B_W(14), .OUT_W(22)) bus_trc ();
  cnn_mac_if #(.A_W(8), .B_W(14), .OUT_W(22)) bus_a24 ();

  assign bus_sat.ce = ce;  assign bus_sat.in_valid = in_valid;
  assign bus_sat.in_first = in_first;  assign bus_sat.in_last = in_last;
  assign bus_sat.din0 = din0;  assign bus_sat.din1 = din1;
  assign bus_trc.ce = ce;  assign bus_trc.in_valid = in_valid;
  assign bus_trc.in_first = in_first;  assign bus_trc.in_last = in_last;
  assign bus_trc.din0 = din0;  assign bus_trc.din1 = din1;
  assign bus_a24.ce = ce;  assign bus_a24.in_valid = in_valid;
  assign bus_a24.in_first = in_first;  assign bus_a24.in_last = in_last;
  assign bus_a24.din0 = din0;  assign bus_a24.din1 = din1;

  cnn_mac_pipe u_sat (.clk(clk), .reset(rst), .bus(bus_sat));
  cnn_mac_pipe #(.SAT_EN(0)) u_trc (.clk(clk), .reset(rst), .bus(bus_trc));
  cnn_mac_pipe #(.ACC_W(24)) u_a24 (.clk(clk), .reset(rst), .bus(bus_a24));

  // Consumer: a result is taken at the next rising edge when out_valid && ce.
  always @(negedge clk) begin
    if (!rst && ce) begin
      if (bus_sat.out_valid) begin
        q_sat.push_back(int'(bus_sat.dout));
        o_sat.push_back(int'(bus_sat.acc_ovf));
      end
      if (bus_trc.out_valid) q_trc.push_back(int'(bus_trc.dout));
      if (bus_a24.out_valid) begin
        q_a24.push_back(int'(bus_a24.dout));
        o_a24.push_back(int'(bus_a24.acc_ovf));
      end
    end
  end

  task automatic chk_eq(input string tag, input logic signed [63:0] got,
                        input logic signed [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_res(input string tag, input int idx, input int e_sat, input int e_trc,
                         input int e_a24, input int e_osat, input int e_oa24);
    chk_eq({tag, " sat dout"}, (idx < q_sat.size()) ? q_sat[idx] : NONE, e_sat);
    chk_eq({tag, " trc dout"}, (idx < q_trc.size()) ? q_trc[idx] : NONE, e_trc);
    chk_eq({tag, " a24 dout"}, (idx < q_a24.size()) ? q_a24[idx] : NONE, e_a24);
    chk_eq({tag, " sat ovf"},  (idx < o_sat.size()) ? o_sat[idx] : NONE, e_osat);
    chk_eq({tag, " a24 ovf"},  (idx < o_a24.size()) ? o_a24[idx] : NONE, e_oa24);
  endtask

  task automatic step(input logic c, input logic v, input logic f, input logic l,
                      input int a, input int b);
    ce = c; in_valid = v; in_first = f; in_last = l;
    din0 = 8'(a); din1 = 14'(b);
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic f, input logic l, input int a, input int b);
    step(1'b1, 1'b1, f, l, a, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic clear_q();
    q_sat.delete(); q_trc.delete(); q_a24.delete(); o_sat.delete(); o_a24.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ce = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    din0 = '0; din1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_eq("reset out_valid", bus_sat.out_valid, 0);
    chk_eq("reset dout", bus_sat.dout, 0);
    chk_eq("reset acc_ovf", bus_sat.acc_ovf, 0);
    rst = 1'b0;
    idle(1);

    // Single-product group, with the latency checked edge by edge.
    clear_q();
    beat(1, 1, -128, 8191);
    chk_eq("t1 lat edge0", bus_sat.out_valid, 0);
    idle(1);
    chk_eq("t1 lat edge1", bus_sat.out_valid, 0);
    idle(1);
    chk_eq("t1 lat edge2 valid", bus_sat.out_valid, 1);
    chk_eq("t1 dout", bus_sat.dout, -1048448);
    chk_eq("t1 trc dout", bus_trc.dout, -1048448);
    chk_eq("t1 acc_ovf", bus_sat.acc_ovf, 0);
    idle(1);
    chk_eq("t1 valid drops", bus_sat.out_valid, 0);
    chk_eq("t1 strobes", q_sat.size(), 1);

    // 3 x 1048576 = 3145728: clamps to 2097151, wraps to -1048576.
    clear_q();
    beat(1, 0, -128, -8192);
    beat(0, 0, -128, -8192);
    beat(0, 1, -128, -8192);
    idle(3);
    chk_eq("t2 strobes", q_sat.size(), 1);
    chk_res("t2", 0, 2097151, -1048576, 2097151, 0, 0);

    // 9 x 1048576 overflows a 24-bit accumulator (wrapped value -7340032).
    clear_q();
    for (int i = 0; i < 9; i++) beat(i == 0, i == 8, -128, -8192);
    idle(3);
    chk_res("t3 big", 0, 2097151, 1048576, -2097152, 0, 1);
    beat(1, 1, 1, 1);
    idle(3);
    chk_res("t3 next", 1, 1, 1, 1, 0, 0);

    // Groups of 2, 1 and 3 beats with bubbles and a 4-cycle stall inside group 3.
    clear_q();
    beat(1, 0, 3, 5);
    idle(1);
    beat(0, 1, -7, 100);
    beat(1, 1, 127, -8192);
    idle(1);
    beat(1, 0, 2, 3);
    chk_eq("t4 B valid", bus_sat.out_valid, 1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1, 99, 99);
      chk_eq("t4 stall hold valid", bus_sat.out_valid, 1);
      chk_eq("t4 stall hold dout", bus_sat.dout, -1040384);
    end
    beat(0, 0, -4, -5);
    chk_eq("t4 valid drops", bus_sat.out_valid, 0);
    idle(1);
    beat(0, 1, 10, -1);
    idle(3);
    chk_eq("t4 strobes", q_sat.size(), 3);
    chk_res("t4 A", 0, -685, -685, -685, 0, 0);
    chk_res("t4 B", 1, -1040384, -1040384, -1040384, 0, 0);
    chk_res("t4 C", 2, 16, 16, 16, 0, 0);

    // Reset with beats in flight clears outputs at once and leaves no residue.
    clear_q();
    beat(1, 0, 7, 7);
    beat(0, 0, 9, 9);
    beat(0, 1, 11, 11);
    chk_eq("t5 dout before reset", bus_sat.dout, 16);
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    rst = 1'b1;
    #1;
    chk_eq("t5 reset valid", bus_sat.out_valid, 0);
    chk_eq("t5 reset dout", bus_sat.dout, 0);
    chk_eq("t5 reset a24 dout", bus_a24.dout, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(4);
    chk_eq("t5 no stale strobe", q_sat.size(), 0);
    beat(0, 0, 1, 1);
    beat(0, 1, 2, 2);
    idle(3);
    chk_eq("t5 strobes", q_sat.size(), 1);
    chk_res("t5", 0, 5, 5, 5, 0, 0);

    // A first inside an open group abandons the old partial sum silently.
    clear_q();
    beat(1, 0, 100, 100);
    beat(0, 0, 50, 50);
    beat(1, 0, 3, 3);
    beat(0, 1, 4, 4);
    idle(3);
    chk_eq("t6 strobes", q_sat.size(), 1);
    chk_res("t6", 0, 25, 25, 25, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
